bshifter_pipe: RTL and testbench

BSHIFTER_PIPE -- requirements
Module: bshifter_pipe

---
 rtl/bshifter_pipe_pkg.sv | 12 +
 rtl/bshifter_pipe_if.sv | 26 ++
 rtl/bshifter_pipe_reverse_n.sv | 14 +
 rtl/bshifter_pipe.sv | 95 +++++++++
 tb/tb_bshifter_pipe.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bshifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter and its bench.
package bshifter_pipe_pkg;

  // Operation select; RSVD behaves as rotate.
  typedef enum logic [1:0] {
    ROT  = 2'b00,
    LSH  = 2'b01,
    ASH  = 2'b10,
    RSVD = 2'b11
  } mode_e;

endpackage

// File: rtl/bshifter_pipe_if.sv
// Valid/ready bundle for the barrel shifter: operand side and result side.
interface bshifter_pipe_if #(
  parameter int W = 16
);
  localparam int S = $clog2(W);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] amt;
  logic         lr;
  logic [1:0]   mode;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (
    output in_valid, in_data, amt, lr, mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, amt, lr, mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bshifter_pipe_reverse_n.sv
// Pure combinational bit reversal of a W-bit vector.
module reverse_n #(
  parameter int W = 16
) (
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Bit i of the output is bit W-1-i of the input.
  for (genvar i = 0; i < W; i++) begin : g_rev
    assign q[i] = d[W-1-i];
  end

endmodule

// File: rtl/bshifter_pipe.sv
// Pipelined logarithmic barrel shifter: one stage per amt bit, left
// operations done by reversing around a right-only shifter.
module bshifter_pipe
  import bshifter_pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  bshifter_pipe_if.slave bus
);

  localparam int S = $clog2(W);

  // Control carried alongside the data; fill is the bit shifted in on
  // non-rotating operations (only arithmetic right uses the sign).
  typedef struct packed {
    logic [S-1:0] amt;
    logic         lr;
    mode_e        mode;
    logic         fill;
  } ctl_t;

  logic [S-1:0][W-1:0] data_q, data_d;
  logic [S-1:0]        valid_q, valid_d;
  ctl_t [S-2:0]        ctl_q, ctl_d;
  logic [S-1:0][W-1:0] stage_in, stage_out;
  ctl_t [S-1:0]        stage_ctl;
  logic [W-1:0]        in_rev, last_rev;
  logic                en;

  function automatic logic [W-1:0] shift_right(logic [W-1:0] x, int unsigned sh,
                                               logic rot, logic fill);
    if (rot)  return (x >> sh) | (x << (W - sh));
    if (fill) return ~((~x) >> sh);
    return x >> sh;
  endfunction

  reverse_n #(.W(W)) u_rev_in  (.d(bus.in_data),     .q(in_rev));
  reverse_n #(.W(W)) u_rev_out (.d(stage_out[S-1]),  .q(last_rev));

  // Whole pipe advances together whenever the output slot can move.
  assign en            = bus.out_ready || !valid_q[S-1];
  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[S-1];
  assign bus.out_data  = data_q[S-1];

  // Per-stage operand/control selection and conditional shift by 2^k.
  always_comb begin
    stage_in     = '0;
    stage_ctl    = '0;
    stage_out    = '0;
    stage_in[0]  = bus.lr ? in_rev : bus.in_data;
    stage_ctl[0] = '{amt:  bus.amt,
                     lr:   bus.lr,
                     mode: mode_e'(bus.mode),
                     fill: (bus.mode == ASH) && !bus.lr && bus.in_data[W-1]};
    for (int k = 1; k < S; k++) begin
      stage_in[k]  = data_q[k-1];
      stage_ctl[k] = ctl_q[k-1];
    end
    for (int k = 0; k < S; k++) begin
      stage_out[k] = stage_ctl[k].amt[k]
                   ? shift_right(stage_in[k], 32'd1 << k,
                                 (stage_ctl[k].mode == ROT) || (stage_ctl[k].mode == RSVD),
                                 stage_ctl[k].fill)
                   : stage_in[k];
    end
  end

  // Next state: each stage result feeds its register; the last one is
  // reversed back for left operations.
  always_comb begin
    data_d  = stage_out;
    if (stage_ctl[S-1].lr) data_d[S-1] = last_rev;
    valid_d = {valid_q[S-2:0], bus.in_valid};
    ctl_d   = stage_ctl[S-2:0];
  end

  // Pipeline registers: reset wins over the enable, otherwise hold on stall.
  // NOTE: state uses non-blocking assignments so every stage samples the
  // previous cycle's values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
      ctl_q   <= '0;
    end else if (en) begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
    end
  end

endmodule

// File: tb/tb_bshifter_pipe.sv
// Scoreboard bench: W=8 directed scenarios and a W=32 random soak.
module tb_bshifter_pipe;
  import bshifter_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst32;

  bshifter_pipe_if #(.W(8))  bus8 ();
  bshifter_pipe_if #(.W(32)) bus32 ();

  bshifter_pipe #(.W(8))  dut8  (.clk(clk), .reset(rst8),  .bus(bus8));
  bshifter_pipe #(.W(32)) dut32 (.clk(clk), .reset(rst32), .bus(bus32));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bitwise reference: output bit i takes the source bit amt away.
  function automatic logic [63:0] ref_model(int w, logic [63:0] d, int amt,
                                            logic lr, logic [1:0] mode);
    logic [63:0] r;
    int src;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (!lr) begin
        src = i + amt;
        if (src < w)                          r[i] = d[src];
        else if (mode == ROT || mode == RSVD) r[i] = d[src-w];
        else if (mode == ASH)                 r[i] = d[w-1];
        else                                  r[i] = 1'b0;
      end else begin
        src = i - amt;
        if (src >= 0)                         r[i] = d[src];
        else if (mode == ROT || mode == RSVD) r[i] = d[src+w];
        else                                  r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  logic [63:0] q8[$];
  logic [63:0] q32[$];
  int del_cyc8[$];
  int cyc8 = 0, del8 = 0, acc32 = 0;

  // One W=8 cycle: drive at the falling edge, score what the next rising
  // edge will accept/deliver, then wait for the next falling edge.
  task automatic step8(input logic v, input logic [7:0] d, input logic [2:0] a,
                       input logic l, input logic [1:0] m, input logic ordy);
    logic [63:0] e;
    bus8.in_valid  = v;
    bus8.in_data   = d;
    bus8.amt       = a;
    bus8.lr        = l;
    bus8.mode      = m;
    bus8.out_ready = ordy;
    #1;
    if (!rst8 && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) check("w8_unexpected_beat", {56'd0, bus8.out_data}, 64'hx);
      else check("w8_data", {56'd0, bus8.out_data}, q8.pop_front());
      del8++;
      del_cyc8.push_back(cyc8);
    end
    if (!rst8 && v && bus8.in_ready) begin
      e = ref_model(8, {56'd0, d}, int'(a), l, m);
      q8.push_back(e);
    end
    @(negedge clk);
    cyc8++;
  endtask

  task automatic step32(input logic v, input logic [31:0] d, input logic [4:0] a,
                        input logic l, input logic [1:0] m, input logic ordy);
    logic [63:0] e;
    bus32.in_valid  = v;
    bus32.in_data   = d;
    bus32.amt       = a;
    bus32.lr        = l;
    bus32.mode      = m;
    bus32.out_ready = ordy;
    #1;
    if (!rst32 && bus32.out_valid && bus32.out_ready) begin
      if (q32.size() == 0) check("w32_unexpected_beat", {32'd0, bus32.out_data}, 64'hx);
      else check("w32_data", {32'd0, bus32.out_data}, q32.pop_front());
    end
    if (!rst32 && v && bus32.in_ready) begin
      e = ref_model(32, {32'd0, d}, int'(a), l, m);
      q32.push_back(e);
      acc32++;
    end
    @(negedge clk);
  endtask

  task automatic idle8(input int n);
    for (int i = 0; i < n; i++) step8(1'b0, 8'h00, 3'd0, 1'b0, ROT, 1'b1);
  endtask

  initial begin
    logic [7:0] held;
    int d_before;

    rst8 = 1'b1;
    rst32 = 1'b1;
    @(negedge clk);

    // ---------------- W=8 directed ----------------
    idle8(2);
    check("reset_out_valid", {63'd0, bus8.out_valid}, 64'd0);
    check("reset_out_data",  {56'd0, bus8.out_data},  64'd0);
    rst8 = 1'b0;
    #1;
    check("in_ready_after_reset", {63'd0, bus8.in_ready}, 64'd1);

    // Latency: accept at edge n, visible only after edge n+2.
    step8(1'b1, 8'hB1, 3'd3, 1'b0, ROT, 1'b1);
    check("lat_edge_n",   {63'd0, bus8.out_valid}, 64'd0);
    idle8(1);
    check("lat_edge_n1",  {63'd0, bus8.out_valid}, 64'd0);
    idle8(1);
    check("lat_edge_n2",  {63'd0, bus8.out_valid}, 64'd1);
    check("rot_r3_b1",    {56'd0, bus8.out_data},  64'h36);
    idle8(2);

    // Shift flavours back to back.
    step8(1'b1, 8'hB1, 3'd3, 1'b0, ASH, 1'b1);
    step8(1'b1, 8'hB1, 3'd3, 1'b1, ASH, 1'b1);
    step8(1'b1, 8'hB1, 3'd3, 1'b0, LSH, 1'b1);
    check("ash_r3_b1", {56'd0, bus8.out_data}, 64'hF6);
    idle8(1);
    check("ash_l3_b1", {56'd0, bus8.out_data}, 64'h88);
    idle8(1);
    check("lsh_r3_b1", {56'd0, bus8.out_data}, 64'h16);
    idle8(2);

    // amt=0 passes through for every mode/direction; amt=7 extremes.
    for (int i = 0; i < 8; i++)
      step8(1'b1, 8'h9C ^ 8'(i), 3'd0, i[0], i[2:1], 1'b1);
    for (int i = 0; i < 8; i++)
      step8(1'b1, 8'hC5, 3'd7, i[0], i[2:1], 1'b1);
    idle8(4);

    // Eight back-to-back beats must emerge on consecutive cycles.
    del_cyc8.delete();
    for (int i = 0; i < 8; i++)
      step8(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 1'b1);
    idle8(5);
    check("burst_count", 64'(del_cyc8.size()), 64'd8);
    if (del_cyc8.size() == 8)
      check("burst_no_gaps", 64'(del_cyc8[7] - del_cyc8[0]), 64'd7);

    // Fill the pipe, then stall the output for five cycles.
    d_before = del8;
    for (int i = 0; i < 3; i++)
      step8(1'b1, 8'h5A + 8'(i), 3'(i + 1), 1'b0, LSH, 1'b1);
    held = bus8.out_data;
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, 8'hEE, 3'd1, 1'b1, ROT, 1'b0);
      check("stall_in_ready",  {63'd0, bus8.in_ready},  64'd0);
      check("stall_out_valid", {63'd0, bus8.out_valid}, 64'd1);
      check("stall_out_data",  {56'd0, bus8.out_data},  {56'd0, held});
    end
    idle8(6);
    check("stall_delivered", 64'(del8 - d_before), 64'd3);
    check("stall_sb_empty",  64'(q8.size()), 64'd0);

    // Reset with two beats in flight; a beat offered during reset is dropped.
    step8(1'b1, 8'h81, 3'd1, 1'b0, ASH, 1'b1);
    step8(1'b1, 8'h7E, 3'd2, 1'b1, ROT, 1'b1);
    rst8 = 1'b1;
    step8(1'b1, 8'h33, 3'd4, 1'b0, ROT, 1'b1);
    check("rst_flight_out_valid", {63'd0, bus8.out_valid}, 64'd0);
    check("rst_flight_out_data",  {56'd0, bus8.out_data},  64'd0);
    q8.delete();
    rst8 = 1'b0;
    d_before = del8;
    idle8(6);
    check("rst_flight_never_delivered", 64'(del8 - d_before), 64'd0);

    // ---------------- W=32 random soak ----------------
    rst32 = 1'b0;
    for (int i = 0; i < 8; i++)
      step32(1'b1, $urandom, (i < 4) ? 5'd0 : 5'd31, i[0], 2'(i), 1'b1);
    for (int n = 0; n < 40000 && acc32 < 10000; n++) begin
      logic [4:0] a;
      int sel;
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd31 : 5'($urandom);
      step32($urandom_range(0, 9) < 8, $urandom, a, 1'($urandom), 2'($urandom),
             $urandom_range(0, 9) < 8);
    end
    for (int n = 0; n < 50 && q32.size() != 0; n++)
      step32(1'b0, 32'd0, 5'd0, 1'b0, ROT, 1'b1);
    check("w32_accepted", 64'(acc32), 64'd10000);
    check("w32_sb_empty", 64'(q32.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
